// File: rtl/natural_log_arbiter.sv
// Round-robin front end that shares one pipelined natural-log unit between NUM_REQ requesters.
// Optional per-requester result cache: define NATURAL_LOG_ARB_CACHE_EN.
module natural_log_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*24-1:0]   in_flat,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ*16-1:0]   res_flat,
  output logic [NUM_REQ-1:0]      res_valid,
  output logic [23:0]             log_in,
  input  logic [15:0]             log_out
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  typedef logic [IDW-1:0] id_t;

  // Handshake: req is a level; grant is a one-cycle acceptance pulse and the
  // requester stays busy until its res_valid pulse, so req may be held high.
  logic [NUM_REQ-1:0][23:0] operand;
  assign operand = in_flat;

  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       busy_q, busy_d;
  id_t                      ptr_q, ptr_d;
  logic [23:0]              log_in_q, log_in_d;
  logic [LOG_LATENCY:0]           tag_vld_q, tag_vld_d;
  logic [LOG_LATENCY:0][IDW-1:0]  tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0][15:0] res_q, res_d, res_out;

  logic [NUM_REQ-1:0]       cache_hit;
  logic [NUM_REQ-1:0]       hit_pulse;
  logic [NUM_REQ-1:0][15:0] hit_res;
  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       retire;

  logic                     found;
  id_t                      win;
  logic [IDW:0]             cand;
  logic [IDW:0]             win_inc;

  assign eligible = req & ~busy_q & ~cache_hit;

  // Search starts at ptr_q and wraps; the first eligible index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(off);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && eligible[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_d  = '0;
    log_in_d = log_in_q;
    ptr_d    = ptr_q;
    win_inc  = {1'b0, win} + 1'b1;
    if (win_inc >= NREQ) win_inc = '0;
    if (found) begin
      grant_d[win] = 1'b1;
      log_in_d     = operand[win];
      ptr_d        = win_inc[IDW-1:0];
    end
  end

  // Stage 0 is aligned with log_in; stage LOG_LATENCY is aligned with the
  // matching log_out value, so retirement reads log_out combinationally.
  always_comb begin
    tag_vld_d = {tag_vld_q[LOG_LATENCY-1:0], found};
    tag_id_d  = {tag_id_q[LOG_LATENCY-1:0], win};
  end

  always_comb begin
    retire = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      retire[i] = tag_vld_q[LOG_LATENCY] && (tag_id_q[LOG_LATENCY] == id_t'(i));
    end
  end

  assign busy_d = (busy_q & ~retire) | grant_d;

  always_comb begin
    res_d   = res_q;
    res_out = res_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (retire[i]) begin
        res_d[i]   = log_out;
        res_out[i] = log_out;
      end else if (cache_hit[i]) begin
        res_d[i] = hit_res[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q   <= '0;
      busy_q    <= '0;
      ptr_q     <= '0;
      log_in_q  <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      res_q     <= '0;
    end else begin
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      log_in_q  <= log_in_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      res_q     <= res_d;
    end
  end

`ifdef NATURAL_LOG_ARB_CACHE_EN
  logic [NUM_REQ-1:0]       cache_vld_q, cache_vld_d;
  logic [NUM_REQ-1:0]       hit_vld_q;
  logic [NUM_REQ-1:0][23:0] cache_in_q, cache_in_d;
  logic [NUM_REQ-1:0][23:0] pend_in_q, pend_in_d;
  logic [NUM_REQ-1:0][15:0] cache_res_q, cache_res_d;

  always_comb begin
    cache_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cache_hit[i] = req[i] & ~busy_q[i] & cache_vld_q[i] & (operand[i] == cache_in_q[i]);
    end
  end

  // pend_in remembers the operand in flight so the retiring result can be keyed by it.
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_in_d  = cache_in_q;
    cache_res_d = cache_res_q;
    pend_in_d   = pend_in_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) pend_in_d[i] = operand[i];
      if (retire[i]) begin
        cache_vld_d[i] = 1'b1;
        cache_in_d[i]  = pend_in_q[i];
        cache_res_d[i] = log_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld_q <= '0;
      hit_vld_q   <= '0;
      cache_in_q  <= '0;
      cache_res_q <= '0;
      pend_in_q   <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      hit_vld_q   <= cache_hit;
      cache_in_q  <= cache_in_d;
      cache_res_q <= cache_res_d;
      pend_in_q   <= pend_in_d;
    end
  end

  assign hit_pulse = hit_vld_q;
  assign hit_res   = cache_res_q;
`else
  assign cache_hit = '0;
  assign hit_pulse = '0;
  assign hit_res   = '0;
`endif

  assign grant     = grant_q;
  assign log_in    = log_in_q;
  assign res_valid = retire | hit_pulse;
  assign res_flat  = res_out;

endmodule

// File: tb/tb_natural_log_arbiter.sv
// Directed bench for natural_log_arbiter with a fixed-latency ln model as the shared unit.
// Cache sequences are selected with NATURAL_LOG_ARB_CACHE_EN.
module tb_natural_log_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*24-1:0] in_flat;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ*16-1:0] res_flat;
  logic [NUM_REQ-1:0]    res_valid;
  logic [23:0]           log_in;
  logic [15:0]           log_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  natural_log_arbiter #(.NUM_REQ(NUM_REQ), .LOG_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .in_flat(in_flat), .grant(grant),
    .res_flat(res_flat), .res_valid(res_valid), .log_in(log_in), .log_out(log_out)
  );

  // Shared unit model: floor(ln(x/256)*256), LAT clocks after log_in changes.
  function automatic logic [15:0] ln_model(input logic [23:0] x);
    real r;
    if (x == 24'd0) return 16'h8000;
    r = $floor($ln(real'(x) / 256.0) * 256.0);
    return 16'($rtoi(r));
  endfunction

  logic [15:0] unit_pipe [LAT];
  always @(posedge clk) begin
    unit_pipe[0] <= ln_model(log_in);
    for (int s = 1; s < LAT; s++) unit_pipe[s] <= unit_pipe[s-1];
  end
  assign log_out = unit_pipe[LAT-1];

  typedef struct {
    int          id;
    logic [23:0] op;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [23:0] v);
    in_flat[24*i +: 24] = v;
  endtask

  function automatic logic [15:0] slot(input int i);
    return res_flat[16*i +: 16];
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    in_flat = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_g, exp_rv;
    logic [15:0]        want;

    vecs[0] = '{2, 24'd512,      16'd177};
    vecs[1] = '{0, 24'd256,      16'd0};
    vecs[2] = '{3, 24'd1024,     16'd354};
    vecs[3] = '{1, 24'd768,      16'd281};
    vecs[4] = '{1, 24'd128,      16'hFF4E};
    vecs[5] = '{0, 24'hFFFFFF,   16'd2839};

    // Reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_valid", res_valid, 0);
    check("rst_res_lo", res_flat[31:0], 0);
    check("rst_res_hi", res_flat[63:32], 0);
    check("rst_log_in", log_in, 0);

    // Single requests from the vector table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_op(vecs[v].id, vecs[v].op);
      req = NUM_REQ'(1) << vecs[v].id;
      for (int c = 1; c <= LAT + 1; c++) begin
        tick();
        exp_g  = (c == 1)       ? NUM_REQ'(1) << vecs[v].id : '0;
        exp_rv = (c == LAT + 1) ? NUM_REQ'(1) << vecs[v].id : '0;
        check("vec_grant", grant, exp_g);
        check("vec_valid", res_valid, exp_rv);
        if (c == 1)       check("vec_log_in", log_in, vecs[v].op);
        if (c == LAT + 1) check("vec_result", slot(vecs[v].id), vecs[v].exp_res);
      end
      req = '0;
      tick();
      check("vec_hold", slot(vecs[v].id), vecs[v].exp_res);
      check("vec_valid_after", res_valid, 0);
    end

    // Fairness: all four request together
    do_reset();
    set_op(0, 24'd256); set_op(1, 24'd512); set_op(2, 24'd768); set_op(3, 24'd1024);
    exp_q.push_back(16'd0); exp_q.push_back(16'd177);
    exp_q.push_back(16'd281); exp_q.push_back(16'd354);
    req = 4'b1111;
    for (int c = 1; c <= 7; c++) begin
      tick();
      case (c)
        1: exp_g = 4'b0001; 2: exp_g = 4'b0010; 3: exp_g = 4'b0100; 4: exp_g = 4'b1000;
        5: exp_g = 4'b0000; 6: exp_g = 4'b0001; default: exp_g = 4'b0010;
      endcase
      exp_rv = (c >= 4) ? NUM_REQ'(1) << (c - 4) : '0;
      check("fair_grant", grant, exp_g);
      check("fair_valid", res_valid, exp_rv);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (res_valid[i]) begin
          if (exp_q.size() == 0) begin
            check("fair_unexpected_result", 1, 0);
          end else begin
            want = exp_q.pop_front();
            check("fair_result", slot(i), want);
          end
        end
      end
    end
    check("fair_all_results_seen", exp_q.size(), 0);
    req = '0;
    repeat (LAT + 3) tick();

    // Rotation between two continuously requesting ports
    do_reset();
    set_op(0, 24'd512); set_op(1, 24'd768);
    req = 4'b0011;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_g  = (c % 5 == 1) ? 4'b0001 : (c % 5 == 2) ? 4'b0010 : 4'b0000;
      exp_rv = (c % 5 == 4) ? 4'b0001 : (c >= 5 && c % 5 == 0) ? 4'b0010 : 4'b0000;
      check("rot_grant", grant, exp_g);
      check("rot_valid", res_valid, exp_rv);
      if (res_valid[0]) check("rot_res0", slot(0), 16'd177);
      if (res_valid[1]) check("rot_res1", slot(1), 16'd281);
    end
    req = '0;
    repeat (LAT + 3) tick();

    // Reset while an operation is in flight
    do_reset();
    set_op(1, 24'd512);
    req = 4'b0010;
    tick();
    check("rmf_grant", grant, 4'b0010);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rmf_valid", res_valid, 0);
      check("rmf_grant_low", grant, 0);
      check("rmf_log_in", log_in, 0);
      check("rmf_res", res_flat[63:0], 0);
    end
    reset = 1'b0;
    tick();
    check("rmf_regrant", grant, 4'b0010);
    check("rmf_regrant_op", log_in, 24'd512);
    req = '0;
    tick();
    tick();
    tick();
    check("rmf_done_valid", res_valid, 4'b0010);
    check("rmf_done_res", slot(1), 16'd177);

    // Idle hold
    for (int c = 0; c < 50; c++) begin
      tick();
      check("idle_log_in", log_in, 24'd512);
      check("idle_grant", grant, 0);
      check("idle_valid", res_valid, 0);
      check("idle_res", slot(1), 16'd177);
    end

    // Repeat of a previous operand
    do_reset();
    set_op(0, 24'd512);
    req = 4'b0001;
    repeat (LAT + 1) tick();
    check("rep_first_valid", res_valid, 4'b0001);
    check("rep_first_res", slot(0), 16'd177);
    req = '0;
    tick();
    req = 4'b0001;
    tick();
`ifdef NATURAL_LOG_ARB_CACHE_EN
    check("cache_hit_valid", res_valid, 4'b0001);
    check("cache_hit_res", slot(0), 16'd177);
    check("cache_hit_grant", grant, 0);
    check("cache_hit_log_in", log_in, 24'd512);
    req = '0;
    tick();
    check("cache_after_valid", res_valid, 0);
    set_op(0, 24'd768);
    req = 4'b0001;
    tick();
    check("cache_miss_grant", grant, 4'b0001);
    check("cache_miss_log_in", log_in, 24'd768);
    req = '0;
    repeat (LAT - 1) tick();
    check("cache_miss_early", res_valid, 0);
    tick();
    check("cache_miss_valid", res_valid, 4'b0001);
    check("cache_miss_res", slot(0), 16'd281);
`else
    check("rep_grant", grant, 4'b0001);
    check("rep_no_early_valid", res_valid, 0);
    req = '0;
    repeat (LAT - 1) tick();
    check("rep_early", res_valid, 0);
    tick();
    check("rep_valid", res_valid, 4'b0001);
    check("rep_res", slot(0), 16'd177);
`endif
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
